mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Single-port arbiter and sequencer for the data memory, shared between the pipeline Memory stage (loads/stores) and the display pixel fetcher. It sits between the Memory stage and the data memory, drives the memory's address, write-data, write-enable and byte-mode inputs, and stalls the pipeline when the CPU cannot be served. The CPU has priority. A starvation counter guarantees the display a slot at least every STARVE_MAX+1 cycles.

## Interface
- ADDR_W, 19, memory address width
- DATA_W, 19, memory data width
- PIX_W, 8, pixel width returned to the display fetcher
- STARVE_MAX, 4, consecutive denied display cycles before display is forced to win
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  Memory stage requests an access; held until not stalled
- cpu_we  in  1  1 = store, 0 = load
- cpu_byte  in  1  byte-mode access, forwarded to memory
- cpu_addr  in  ADDR_W  ALU result address
- cpu_wdata  in  DATA_W  store data
- cpu_stall  out  1  freeze IF..MEM pipeline registers
- cpu_rdata  out  DATA_W  load data, valid when cpu_rvalid=1
- cpu_rvalid  out  1  load data returned this cycle
- disp_req  in  1  display fetcher requests a pixel read
- disp_addr  in  ADDR_W  pixel address
- disp_gnt  out  1  display request issued to memory this cycle
- disp_rdata  out  PIX_W  pixel, valid when disp_rvalid=1
- disp_rvalid  out  1  pixel returned this cycle (1 cycle after disp_gnt)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_byte  out  1  memory byte mode
- mem_rdata  in  DATA_W  memory read data; synchronous read, valid the cycle after address

## Operation
- FSM states: IDLE, CPU_RD.
  - IDLE: a CPU request is "new" when cpu_req=1.
  - CPU_RD: a CPU load was issued last cycle. cpu_req is ignored as a new request (same access still held). cpu_rvalid=1. Always returns to IDLE next cycle.
- Arbitration in IDLE or CPU_RD, per cycle:
  - CPU only (new) → CPU granted.
  - Display only → display granted.
  - Both → CPU granted, unless starve_cnt == STARVE_MAX, in which case the display is granted.
- Starvation counter:
  - starve_cnt increments when disp_req=1 and disp_gnt=0, saturating at STARVE_MAX.
  - Clears to 0 on disp_gnt=1 or when disp_req=0.
- CPU store granted: mem_we=1 for exactly that cycle, cpu_stall=0, no state change.
- CPU load granted: IDLE→CPU_RD, cpu_stall=1 in the issue cycle. Next cycle cpu_rvalid=1, cpu_stall=0, and cpu_rdata=mem_rdata (combinational pass-through).
- CPU new request denied (display wins): cpu_stall=1, and the request is re-arbitrated next cycle.
- Display grant: mem_addr=disp_addr, mem_we=0. A 1-bit rd_owner_disp register is set, so disp_rvalid=1 next cycle with disp_rdata=mem_rdata[PIX_W-1:0].
- Memory drive in a cycle with no grant: mem_addr=0, mem_wdata=0, mem_we=0, mem_byte=0.
- mem_wdata and mem_byte follow the CPU only on a CPU grant.
- Display read back-to-back with a CPU load return is legal: the display is granted in the CPU_RD cycle.

## Timing
- Arbitration and memory drive are combinational from the requests and registered state. The memory samples at the next rising edge.
- Load latency: issue cycle N (stall), data cycle N+1, so the pipeline loses 1 cycle per load. Store latency is 0 stall cycles when granted.
- Display read latency: 1 cycle from disp_gnt to disp_rvalid. Throughput is 1 pixel per cycle when the CPU is idle.
- Reset (asynchronous, active-high), at any time including mid-load:
  - state=IDLE, starve_cnt=0, rd_owner_disp=0.
  - The in-flight read is dropped, and no rvalid is produced after reset release.
  - While reset=1: cpu_stall=0, cpu_rvalid=0, disp_gnt=0, disp_rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_byte=0, cpu_rdata=0, disp_rdata=0.
- Worst-case display wait under continuous CPU traffic: STARVE_MAX cycles denied, then granted on the next cycle.

## Structure
- Package mem_arb_pkg:
  - ADDR_W, DATA_W, PIX_W constants.
  - typedef enum logic {IDLE, CPU_RD} arb_state_t.
  - typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_DISP} gnt_t.
- One sub-module, arb_starve_counter: saturating counter with inc/clr inputs and a hit output (cnt==STARVE_MAX).
- The top level holds the FSM, the grant decode and the memory mux.

## Test plan
- Reset mid-load: cpu_req=1, cpu_we=0, reset pulsed in the issue cycle → no cpu_rvalid afterwards, all outputs 0, state IDLE.
- CPU store alone: cpu_addr=0x00040, cpu_wdata=0x1ABCD → same cycle mem_we=1, mem_addr=0x00040, mem_wdata=0x1ABCD, cpu_stall=0.
- CPU load alone: mem_rdata model returns 0x12345 → cycle N cpu_stall=1; cycle N+1 cpu_rvalid=1, cpu_rdata=0x12345, cpu_stall=0.
- Display only, 3 consecutive requests, addrs 0x100..0x102 → disp_gnt=1 in each cycle; disp_rvalid on cycles +1..+3 with the pixel bytes in order.
- Starvation, STARVE_MAX=4: cpu_req stores every cycle with disp_req held → display denied 4 cycles, granted on the 5th; cpu_stall=1 that cycle; starve_cnt back to 0.
- Load plus display overlap: load issued cycle N with disp_req=1 → display granted cycle N+1 alongside cpu_rvalid; disp_rvalid at N+2.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, state and grant encodings for the data-memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W         = 19;
    localparam int DATA_W         = 19;
    localparam int PIX_W          = 8;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic {
        IDLE,
        CPU_RD
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_DISP
    } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, display and memory signals of the arbiter, bundled with one modport per side.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
();

    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_byte;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic [PIX_W-1:0]  disp_rdata;
    logic              disp_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_byte;
    logic [DATA_W-1:0] mem_rdata;

    // The arbiter itself.
    modport slave (
        input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
        input  disp_req, disp_addr,
        input  mem_rdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        output disp_gnt, disp_rdata, disp_rvalid,
        output mem_addr, mem_wdata, mem_we, mem_byte
    );

    // The surrounding system: pipeline, fetcher and memory.
    modport master (
        output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
        output disp_req, disp_addr,
        output mem_rdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        input  disp_gnt, disp_rdata, disp_rvalid,
        input  mem_addr, mem_wdata, mem_we, mem_byte
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive denied display cycles; hit forces the display to win.
module arb_starve_counter #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != W'(MAX))) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_hit = (r_cnt == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data-memory arbiter: CPU has priority, display is guaranteed a slot
// after STARVE_MAX denied cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       r_rd_owner_disp;
    gnt_t       w_gnt;
    logic       w_cpu_new;
    logic       w_hit;
    logic       w_starve_inc;

    // In CPU_RD the held request belongs to the load already in flight.
    assign w_cpu_new    = (r_state == IDLE) && bus.cpu_req && !reset;
    assign w_starve_inc = bus.disp_req && (w_gnt != GNT_DISP);

    arb_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_starve_inc),
        .i_clr (!w_starve_inc),
        .o_hit (w_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_rd_owner_disp <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_rd_owner_disp <= (w_gnt == GNT_DISP);
        end
    end

    always_comb begin
        w_gnt          = GNT_NONE;
        w_state_next   = IDLE;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_we     = 1'b0;
        bus.mem_byte   = 1'b0;
        bus.cpu_stall  = 1'b0;
        bus.disp_gnt   = 1'b0;

        if (!reset) begin
            if (w_cpu_new && !(bus.disp_req && w_hit)) begin
                w_gnt = GNT_CPU;
            end else if (bus.disp_req) begin
                w_gnt = GNT_DISP;
            end
        end

        case (w_gnt)
            GNT_CPU: begin
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
                bus.mem_we    = bus.cpu_we;
                bus.mem_byte  = bus.cpu_byte;
                bus.cpu_stall = !bus.cpu_we;
                if (!bus.cpu_we) begin
                    w_state_next = CPU_RD;
                end
            end
            GNT_DISP: begin
                bus.mem_addr  = bus.disp_addr;
                bus.disp_gnt  = 1'b1;
                bus.cpu_stall = w_cpu_new;
            end
            default: begin
                bus.cpu_stall = w_cpu_new;
            end
        endcase
    end

    assign bus.cpu_rvalid  = (r_state == CPU_RD);
    assign bus.cpu_rdata   = bus.cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.disp_rvalid = r_rd_owner_disp;
    assign bus.disp_rdata  = r_rd_owner_disp ? bus.mem_rdata[PIX_W-1:0] : '0;

endmodule
